// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

  localparam int WORD_SIZE = 16;
  localparam logic [WORD_SIZE-1:0] INSTR_RESET = 16'h0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_VALID = 2'd2,
    IF_DROP  = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-controller bus: PC load port, instruction-memory handshake and IF/ID side.
interface if_fetch_ctrl_if #(
  parameter int WORD_SIZE = if_fetch_ctrl_pkg::WORD_SIZE
);
  logic [WORD_SIZE-1:0] pc_cur;
  logic [WORD_SIZE-1:0] pc_next;
  logic                 update_pc;
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;
  logic                 id_stall;
  logic                 id_redirect;
  logic [WORD_SIZE-1:0] id_target;
  logic                 if_valid;
  logic [WORD_SIZE-1:0] if_instr;
  logic [WORD_SIZE-1:0] if_pc;

  modport master (
    input  pc_cur, i_data, i_ready, id_stall, id_redirect, id_target,
    output pc_next, update_pc, i_readM, i_address, if_valid, if_instr, if_pc
  );

  modport slave (
    output pc_cur, i_data, i_ready, id_stall, id_redirect, id_target,
    input  pc_next, update_pc, i_readM, i_address, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC -> imem request/ready -> IF/ID valid/stall.
// Optional IF_FETCH_COUNT_EN adds num_fetch, a count of consumed instructions.
module if_fetch_ctrl #(
  parameter int WORD_SIZE = if_fetch_ctrl_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] INSTR_RESET = if_fetch_ctrl_pkg::INSTR_RESET
) (
  input  logic          clk,
  input  logic          reset_n,
`ifdef IF_FETCH_COUNT_EN
  output logic [WORD_SIZE-1:0] num_fetch,
`endif
  if_fetch_ctrl_if.master bus
);
  import if_fetch_ctrl_pkg::*;

  if_state_e            state, state_n;
  logic                 rd_q, rd_n;
  logic [WORD_SIZE-1:0] addr_q, addr_n;
  logic                 vld_q, vld_n;
  logic [WORD_SIZE-1:0] instr_q, instr_n;
  logic [WORD_SIZE-1:0] ipc_q, ipc_n;
  logic                 upd;
  logic [WORD_SIZE-1:0] pcn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IF_IDLE;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= INSTR_RESET;
      ipc_q   <= '0;
    end else begin
      state   <= state_n;
      rd_q    <= rd_n;
      addr_q  <= addr_n;
      vld_q   <= vld_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
    end
  end

  always_comb begin
    state_n = state;
    rd_n    = rd_q;
    addr_n  = addr_q;
    vld_n   = vld_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    upd     = 1'b0;
    pcn     = bus.pc_cur;
    // A redirect always reloads the PC, whatever the state.
    if (bus.id_redirect) begin
      upd = 1'b1;
      pcn = bus.id_target;
    end
    case (state)
      IF_IDLE: begin
        if (!bus.id_redirect) begin
          rd_n    = 1'b1;
          addr_n  = bus.pc_cur;
          state_n = IF_REQ;
        end
      end
      IF_REQ: begin
        if (bus.id_redirect) begin
          // An in-flight request cannot be withdrawn; wait it out in DROP.
          if (bus.i_ready) begin
            rd_n    = 1'b0;
            state_n = IF_IDLE;
          end else begin
            state_n = IF_DROP;
          end
        end else if (bus.i_ready) begin
          instr_n = bus.i_data;
          ipc_n   = addr_q;
          vld_n   = 1'b1;
          rd_n    = 1'b0;
          upd     = 1'b1;
          pcn     = addr_q + WORD_SIZE'(1);
          state_n = IF_VALID;
        end
      end
      IF_VALID: begin
        if (bus.id_redirect) begin
          vld_n   = 1'b0;
          instr_n = INSTR_RESET;
          state_n = IF_IDLE;
        end else if (!bus.id_stall) begin
          rd_n    = 1'b1;
          addr_n  = bus.pc_cur;
          vld_n   = 1'b0;
          state_n = IF_REQ;
        end
      end
      IF_DROP: begin
        if (bus.i_ready) begin
          rd_n    = 1'b0;
          state_n = IF_IDLE;
        end
      end
      default: state_n = IF_IDLE;
    endcase
  end

  assign bus.pc_next   = pcn;
  assign bus.update_pc = upd;
  assign bus.i_readM   = rd_q;
  assign bus.i_address = addr_q;
  assign bus.if_valid  = vld_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;

`ifdef IF_FETCH_COUNT_EN
  logic consume;
  assign consume = (state == IF_VALID) && !bus.id_stall && !bus.id_redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     num_fetch <= '0;
    else if (consume) num_fetch <= num_fetch + WORD_SIZE'(1);
  end
`endif

endmodule
